// File: rtl/param_coeff_loader.sv
// Sequences NUM_COEFF load_coeff strobes into the FIR datapath, each gated by modwait, then ends the set.
// load_coeff one cycle after the request edge; holds in WAIT while modwait is high; repeat requests queue as one pending set.
module param_coeff_loader #(
  parameter int NUM_COEFF = 4,
  parameter bit CLEAR_EN  = 1'b1,
  localparam int IDX_W    = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             new_coefficient_set,
  input  logic             abort,
  input  logic             modwait,
  output logic             load_coeff,
  output logic [IDX_W-1:0] coefficient_num,
  output logic             clear_coeff,
  output logic             load_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             pending, pending_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = pending;
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      idx_nxt     = '0;
      pending_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx_nxt     = '0;
          pending_nxt = 1'b0;
          if (new_coefficient_set) state_nxt = LOAD;
        end
        LOAD: begin
          state_nxt   = WAIT;
          pending_nxt = pending | new_coefficient_set;
        end
        WAIT: begin
          pending_nxt = pending | new_coefficient_set;
          if (!modwait) begin
            if (idx == LAST_IDX) begin
              state_nxt = CLEAR;
              idx_nxt   = '0;
            end else begin
              state_nxt = LOAD;
              idx_nxt   = idx + IDX_ONE;
            end
          end
        end
        CLEAR: begin
          // A request landing in the CLEAR cycle counts as pending and restarts immediately.
          idx_nxt     = '0;
          pending_nxt = 1'b0;
          state_nxt   = (pending || new_coefficient_set) ? LOAD : IDLE;
        end
        default: begin
          state_nxt   = IDLE;
          idx_nxt     = '0;
          pending_nxt = 1'b0;
        end
      endcase
    end
  end

  assign load_coeff      = (state == LOAD);
  assign coefficient_num = (state == LOAD || state == WAIT) ? idx : '0;
  assign clear_coeff     = CLEAR_EN && (state == CLEAR);
  assign load_done       = (state == CLEAR);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_param_coeff_loader.sv
// Bench for param_coeff_loader: three instances (4 taps with clear, 1 and 8 taps without) against a step-count model.
module tb_param_coeff_loader;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic new_set = 1'b0;
  logic abort = 1'b0;
  logic modwait = 1'b0;

  always #5 clk = ~clk;

  logic load4, clr4, done4, busy4;
  logic [1:0] num4;
  logic load1, clr1, done1, busy1;
  logic [0:0] num1;
  logic load8, clr8, done8, busy8;
  logic [2:0] num8;

  param_coeff_loader #(.NUM_COEFF(4), .CLEAR_EN(1'b1)) dut4 (
    .clk(clk), .n_rst(n_rst), .new_coefficient_set(new_set), .abort(abort), .modwait(modwait),
    .load_coeff(load4), .coefficient_num(num4), .clear_coeff(clr4), .load_done(done4), .busy(busy4));
  param_coeff_loader #(.NUM_COEFF(1), .CLEAR_EN(1'b0)) dut1 (
    .clk(clk), .n_rst(n_rst), .new_coefficient_set(new_set), .abort(abort), .modwait(modwait),
    .load_coeff(load1), .coefficient_num(num1), .clear_coeff(clr1), .load_done(done1), .busy(busy1));
  param_coeff_loader #(.NUM_COEFF(8), .CLEAR_EN(1'b0)) dut8 (
    .clk(clk), .n_rst(n_rst), .new_coefficient_set(new_set), .abort(abort), .modwait(modwait),
    .load_coeff(load8), .coefficient_num(num8), .clear_coeff(clr8), .load_done(done8), .busy(busy8));

  int checks = 0;
  int errors = 0;

  // Model: step -1 = idle; steps 0..2N-1 alternate issue (even) / wait (odd) for coefficient step/2; step 2N = end of set.
  int step[3] = '{-1, -1, -1};
  int pend[3] = '{0, 0, 0};
  int nc[3]   = '{4, 1, 8};
  int ce[3]   = '{1, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int s, n;
      logic [31:0] o_load, o_num, o_clr, o_done, o_busy;
      s = step[i];
      n = nc[i];
      case (i)
        0: begin o_load = 32'(load4); o_num = 32'(num4); o_clr = 32'(clr4); o_done = 32'(done4); o_busy = 32'(busy4); end
        1: begin o_load = 32'(load1); o_num = 32'(num1); o_clr = 32'(clr1); o_done = 32'(done1); o_busy = 32'(busy1); end
        default: begin o_load = 32'(load8); o_num = 32'(num8); o_clr = 32'(clr8); o_done = 32'(done8); o_busy = 32'(busy8); end
      endcase
      check($sformatf("n%0d_load", n), o_load, 32'(s >= 0 && s < 2*n && s % 2 == 0));
      check($sformatf("n%0d_num", n), o_num, (s >= 0 && s < 2*n) ? 32'(s / 2) : 32'd0);
      check($sformatf("n%0d_done", n), o_done, 32'(s == 2*n));
      check($sformatf("n%0d_clear", n), o_clr, 32'(s == 2*n && ce[i] == 1));
      check($sformatf("n%0d_busy", n), o_busy, 32'(s >= 0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!n_rst) begin
        step[i] = -1;
        pend[i] = 0;
      end else if (step[i] < 0) begin
        if (new_set) step[i] = 0;
      end else if (abort) begin
        step[i] = -1;
        pend[i] = 0;
      end else if (step[i] == 2*nc[i]) begin
        step[i] = (pend[i] != 0 || new_set) ? 0 : -1;
        pend[i] = 0;
      end else begin
        if (new_set) pend[i] = 1;
        if (step[i] % 2 == 0 || !modwait) step[i]++;
      end
    end
    compare_all();
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 60 && busy4; t++) tick();
    check(tag, 32'(busy4), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc[$], ln[$], dc[$], cc[$];
    int cnt_load, cnt_done, cnt_clr;

    // Reset state, then asynchronous reset in the middle of WAIT
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    check("rst_busy", 32'(busy4), 32'd0);
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    modwait = 1'b1;
    tick();
    tick();
    check("t1_in_wait", 32'(busy4 && !load4), 32'd1);
    n_rst = 1'b0;
    #1;
    check("t1_async", 32'({load4, clr4, done4, busy4, load1, done1, busy1, load8, done8, busy8}), 32'd0);
    tick();
    n_rst = 1'b1;
    modwait = 1'b0;
    tick();
    check("t1_idle_after", 32'(busy4), 32'd0);

    // Request at cycle 0, modwait low: loads at 1,3,5,7 and end of set at 9
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (load4) begin lc.push_back(c); ln.push_back(int'(num4)); end
      if (done4) dc.push_back(c);
      if (clr4) cc.push_back(c);
      tick();
    end
    check("t2_nloads", lc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t2_load_cycle", (k < lc.size()) ? lc[k] : -1, 2*k + 1);
      check("t2_load_num", (k < ln.size()) ? ln[k] : -1, k);
    end
    check("t2_ndone", dc.size(), 1);
    check("t2_done_cycle", (dc.size() > 0) ? dc[0] : -1, 9);
    check("t2_clear_cycle", (cc.size() == 1) ? cc[0] : -1, 9);

    // modwait high for 5 cycles after each load
    wait_idle("t3_idle");
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t3_load", 32'(load4), 32'd1);
      check("t3_num", 32'(num4), k);
      modwait = 1'b1;
      repeat (5) tick();
      check("t3_no_extra", 32'({load4, done4}), 32'd0);
      modwait = 1'b0;
      tick();
    end
    check("t3_done", 32'({done4, clr4}), 32'b11);
    tick();
    check("t3_idle_end", 32'(busy4), 32'd0);

    // Abort while waiting on coefficient 2
    wait_idle("t4_idle");
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    for (int t = 0; t < 20 && !(load4 && num4 == 2'd2); t++) tick();
    check("t4_reach_idx2", 32'(load4 && num4 == 2'd2), 32'd1);
    modwait = 1'b1;
    tick();
    check("t4_wait_idx2", 32'({busy4, load4, num4}), 32'b1010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    modwait = 1'b0;
    check("t4_aborted", 32'({busy4, done4, clr4}), 32'd0);
    tick();
    check("t4_no_done", 32'({done4, clr4}), 32'd0);
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    check("t4_restart", 32'({load4, num4}), 32'b100);

    // Second request mid-set queues one set; a third in the same set collapses
    wait_idle("t5_idle");
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    for (int t = 0; t < 20 && num4 != 2'd1; t++) tick();
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    for (int t = 0; t < 20 && num4 != 2'd3; t++) tick();
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    for (int t = 0; t < 20 && !done4; t++) tick();
    check("t5_first_done", 32'(done4), 32'd1);
    tick();
    check("t5_back_to_back", 32'({load4, num4}), 32'b100);
    cnt_load = 0;
    cnt_done = 0;
    for (int t = 0; t < 20; t++) begin
      cnt_load += int'(load4);
      cnt_done += int'(done4);
      tick();
    end
    check("t5_second_loads", cnt_load, 4);
    check("t5_second_done", cnt_done, 1);
    check("t5_idle", 32'(busy4), 32'd0);

    // 1-tap and 8-tap instances with clear disabled
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    new_set = 1'b1;
    tick();
    new_set = 1'b0;
    lc.delete();
    ln.delete();
    cnt_done = 0;
    cnt_clr = 0;
    for (int t = 0; t < 25; t++) begin
      if (load8) ln.push_back(int'(num8));
      if (load1) lc.push_back(int'(num1));
      cnt_done += int'(done8) + 16 * int'(done1);
      cnt_clr += int'(clr8) + int'(clr1);
      tick();
    end
    check("t6_n8_loads", ln.size(), 8);
    for (int k = 0; k < 8; k++) check("t6_n8_num", (k < ln.size()) ? ln[k] : -1, k);
    check("t6_n1_loads", lc.size(), 1);
    check("t6_n1_num", (lc.size() > 0) ? lc[0] : -1, 0);
    check("t6_done_counts", cnt_done, 17);
    check("t6_clear_zero", cnt_clr, 0);

    // Randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      new_set = ($urandom % 8) == 0;
      abort   = ($urandom % 24) == 0;
      modwait = ($urandom % 3) != 0;
      tick();
    end
    new_set = 1'b0;
    abort = 1'b0;
    modwait = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
